// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, addressing-mode codes and register indices.
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, XFER, WB, FIN} state_t;
   localparam logic [1:0] IA = 2'b10, IB = 2'b11, DA = 2'b00, DB = 2'b01;
   localparam int WORD_BYTES = 4;
   localparam logic [3:0] R0 = 4'd0, R1 = 4'd1, R2 = 4'd2, R3 = 4'd3;
   localparam logic [3:0] R4 = 4'd4, R5 = 4'd5, R6 = 4'd6, R7 = 4'd7;
   localparam logic [3:0] R8 = 4'd8, R9 = 4'd9, R10 = 4'd10, R11 = 4'd11;
   localparam logic [3:0] R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, R15 = 4'd15;
   localparam logic [3:0] LR = 4'd14, PC = 4'd15;
endpackage

// File: rtl/block_xfer_seq_if.sv
// block_xfer_seq_if: memory bus and register-bank ports of the transfer sequencer.
interface block_xfer_seq_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_rdata;
   logic [3:0]        rf_read_select;
   logic [ADDR_W-1:0] rf_read_data;
   logic [3:0]        rf_write_select;
   logic              rf_write_en;
   logic [ADDR_W-1:0] rf_write_data;
   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, rf_read_select,
             rf_write_select, rf_write_en, rf_write_data,
      input  mem_ack, mem_rdata, rf_read_data
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, rf_read_select,
             rf_write_select, rf_write_en, rf_write_data,
      output mem_ack, mem_rdata, rf_read_data
   );
endinterface

// File: rtl/reg_list_scan.sv
// reg_list_scan: lowest set index, remaining list and popcount of a 16-bit register list.
module reg_list_scan (
   input  logic [15:0] list,
   output logic [3:0]  idx,
   output logic        valid,
   output logic [15:0] rest,
   output logic [4:0]  count
);
   always_comb begin
      idx = '0;
      count = '0;
      for (int i = 15; i >= 0; i--) idx = list[i] ? 4'(i) : idx;
      for (int i = 0; i < 16; i++) count = count + 5'(list[i]);
   end
   assign valid = |list;
   assign rest = list & (list - 16'd1);
endmodule

// File: rtl/block_xfer_seq.sv
// block_xfer_seq: LDM/STM sequencer walking a register list lowest-first, one memory transfer per ack.
module block_xfer_seq
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              is_load,
   input  logic              up,
   input  logic              pre,
   input  logic              writeback,
   input  logic [3:0]        base_sel,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       reg_list,
   block_xfer_seq_if.master  bus,
   output logic              busy,
   output logic              done
);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
   state_t            state;
   logic [15:0]       pending, scan_in, rest;
   logic [3:0]        idx, bsel_q;
   logic              valid, ld_q, wb_q;
   logic [4:0]        cnt;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] span, first, wb_val;
   // In IDLE the scanner looks at the incoming list so N is known at start.
   assign scan_in = state == IDLE ? reg_list : pending;
   reg_list_scan scan (.list(scan_in), .idx, .valid, .rest, .count(cnt));
   assign mode = {up, pre};
   assign span = ADDR_W'(cnt) * STEP;
   assign first = mode == IA ? base_addr :
                  mode == IB ? base_addr + STEP :
                  mode == DA ? base_addr - span + STEP : base_addr - span;
   assign bus.mem_we = bus.mem_req & ~ld_q;
   assign bus.mem_wdata = bus.mem_we ? bus.rf_read_data : '0;
   assign bus.rf_read_select = state == XFER && !ld_q ? idx : '0;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         pending <= '0;
         ld_q <= 1'b0;
         wb_q <= 1'b0;
         bsel_q <= '0;
         wb_val <= '0;
         bus.mem_req <= 1'b0;
         bus.mem_addr <= '0;
         bus.rf_write_en <= 1'b0;
         bus.rf_write_select <= '0;
         bus.rf_write_data <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         bus.rf_write_en <= 1'b0;
         case (state)
            IDLE: if (start) begin
               ld_q <= is_load;
               bsel_q <= base_sel;
               pending <= reg_list;
               wb_val <= up ? base_addr + span : base_addr - span;
               // A loaded base register keeps the loaded value.
               wb_q <= writeback & valid & ~(is_load & reg_list[base_sel]);
               busy <= 1'b1;
               bus.mem_req <= valid;
               bus.mem_addr <= valid ? first & ~ADDR_W'(3) : '0;
               state <= valid ? XFER : FIN;
               done <= ~valid;
            end
            XFER: if (bus.mem_ack) begin
               pending <= rest;
               bus.mem_req <= |rest;
               bus.mem_addr <= |rest ? bus.mem_addr + STEP : '0;
               bus.rf_write_en <= ld_q;
               bus.rf_write_select <= idx;
               bus.rf_write_data <= bus.mem_rdata;
               state <= |rest ? XFER : wb_q ? WB : FIN;
               done <= ~(|rest) & ~wb_q;
            end
            WB: begin
               bus.rf_write_en <= 1'b1;
               bus.rf_write_select <= bsel_q;
               bus.rf_write_data <= wb_val;
               state <= FIN;
               done <= 1'b1;
            end
            FIN: begin
               state <= IDLE;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_block_xfer_seq.sv
// tb_block_xfer_seq: scoreboard bench with a list-level reference model for block_xfer_seq.
module tb_block_xfer_seq;
   typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} mem_t;
   typedef struct {logic [3:0] sel; logic [31:0] data; bit ld;} rfw_t;
   logic        clk, reset_n, start, is_load, up, pre, writeback, busy, done;
   logic [3:0]  base_sel;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic [31:0] regs [16];
   mem_t        mem_q[$];
   rfw_t        rf_q[$];
   int          ld_ack_q[$];
   int          checks = 0, failures = 0, cyc = 0, ack_cnt = 0, ack_delay = 0;
   bit          stall_prev = 0;
   logic [31:0] prev_addr, prev_wdata;
   mem_t        m;
   rfw_t        w;
   block_xfer_seq_if #(.ADDR_W(32)) bus ();
   block_xfer_seq #(.ADDR_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load), .up(up), .pre(pre),
      .writeback(writeback), .base_sel(base_sel), .base_addr(base_addr), .reg_list(reg_list),
      .bus(bus), .busy(busy), .done(done)
   );
   function automatic logic [31:0] mdata(logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A00_00C3;
   endfunction
   assign bus.mem_rdata = mdata(bus.mem_addr);
   assign bus.rf_read_data = regs[bus.rf_read_select];
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   // Memory responder: ack tied high, or ack after ack_delay waiting cycles.
   initial begin
      int cnt = 0;
      bus.mem_ack = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ack_delay == 0) bus.mem_ack = 1;
         else if (bus.mem_ack) begin bus.mem_ack = 0; cnt = 0; end
         else if (bus.mem_req) begin
            if (cnt == ack_delay) bus.mem_ack = 1;
            else cnt++;
         end else cnt = 0;
      end
   end
   always @(negedge clk) begin
      if (bus.mem_req && stall_prev) begin
         chk("addr_stable", bus.mem_addr, prev_addr);
         chk("wdata_stable", bus.mem_wdata, prev_wdata);
      end
      if (bus.mem_req && bus.mem_ack) begin
         ack_cnt++;
         chk("mem_expected", 32'(mem_q.size() != 0), 32'd1);
         if (mem_q.size() != 0) begin
            m = mem_q.pop_front();
            chk("mem_addr", bus.mem_addr, m.addr);
            chk("mem_we", 32'(bus.mem_we), 32'(m.we));
            if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
         end
         if (!bus.mem_we) ld_ack_q.push_back(cyc);
      end
      if (bus.rf_write_en) begin
         chk("rf_expected", 32'(rf_q.size() != 0), 32'd1);
         if (rf_q.size() != 0) begin
            w = rf_q.pop_front();
            chk("rf_sel", 32'(bus.rf_write_select), 32'(w.sel));
            chk("rf_data", bus.rf_write_data, w.data);
            if (w.ld) chk("ld_lag", 32'(cyc - (ld_ack_q.size() != 0 ? ld_ack_q.pop_front() : -100)), 32'd1);
         end
      end
      stall_prev = reset_n && bus.mem_req && !bus.mem_ack;
      prev_addr = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
   end
   // Reference model: transfers in ascending register order from the lowest block address.
   task automatic model(input logic [15:0] list, input logic [31:0] base, input bit u, p, ld, wb,
                        input logic [3:0] bs, output int lat);
      int n = $countones(list);
      int k = 0;
      bit do_wb;
      logic [31:0] lo, a;
      lo = u ? base + (p ? 32'd4 : 32'd0) : base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
      for (int r = 0; r < 16; r++) if (list[r]) begin
         a = lo + 32'(4 * k);
         mem_q.push_back('{a, !ld, regs[r]});
         if (ld) rf_q.push_back('{4'(r), mdata(a), 1'b1});
         k++;
      end
      do_wb = wb && n > 0 && !(ld && list[bs]);
      if (do_wb) rf_q.push_back('{bs, u ? base + 32'(4 * n) : base - 32'(4 * n), 1'b0});
      lat = n == 0 ? 1 : n + 1 + int'(do_wb);
   endtask
   task automatic check_reset_outputs();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rf_we", 32'(bus.rf_write_en), 0);
      chk("rst_rf_wsel", 32'(bus.rf_write_select), 0);
      chk("rst_rf_wdata", bus.rf_write_data, 0);
      chk("rst_rf_rsel", 32'(bus.rf_read_select), 0);
   endtask
   task automatic launch(input logic [15:0] list, input logic [31:0] base, input bit u, p, ld, wb,
                         input logic [3:0] bs, input int delay, output int lat);
      ack_delay = delay;
      @(posedge clk);
      #1;
      model(list, base, u, p, ld, wb, bs, lat);
      reg_list = list; base_addr = base; up = u; pre = p; is_load = ld; writeback = wb; base_sel = bs;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
   endtask
   task automatic run(input logic [15:0] list, input logic [31:0] base, input bit u, p, ld, wb,
                      input logic [3:0] bs, input int delay, input bit check_lat, input bit poke);
      int exp_lat, lat = 0;
      bit got = 0;
      launch(list, base, u, p, ld, wb, bs, delay, exp_lat);
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk("busy_after_start", 32'(busy), 1);
         if (poke && lat == 2) begin start = 1; reg_list = ~list; is_load = ~ld; end
         if (poke && lat == 3) start = 0;
         if (done) got = 1;
      end
      start = 0;
      chk("done_seen", 32'(got), 1);
      if (check_lat) chk("latency", 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
      chk("busy_idle", 32'(busy), 0);
      chk("mem_q_drained", 32'(mem_q.size()), 0);
      chk("rf_q_drained", 32'(rf_q.size()), 0);
   endtask
   initial begin
      int lat, n;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      reset_n = 0; start = 0; is_load = 0; up = 0; pre = 0; writeback = 0;
      base_sel = 0; base_addr = 0; reg_list = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      reset_n = 1;
      run(16'h000B, 32'h0000_0100, 1, 0, 0, 0, 4'd0, 0, 1, 0);
      run(16'h8003, 32'h0000_0200, 0, 1, 1, 1, 4'd13, 0, 1, 0);
      run(16'h0004, 32'h0000_0300, 1, 0, 1, 1, 4'd2, 0, 1, 0);
      run(16'h0000, 32'h0000_0400, 0, 0, 0, 1, 4'd5, 0, 1, 0);
      run(16'h00F0, 32'h0000_0500, 1, 1, 0, 1, 4'd9, 3, 0, 1);
      run(16'hC001, 32'h0000_0008, 0, 1, 0, 1, 4'd1, 0, 1, 0);
      // Abort a 4-register load during its 2nd transfer.
      launch(16'h1111, 32'h0000_0800, 1, 0, 1, 1, 4'd3, 2, lat);
      n = ack_cnt;
      lat = 0;
      while (ack_cnt == n && lat < 100) begin @(negedge clk); lat++; end
      chk("first_ack_seen", 32'(ack_cnt > n), 1);
      @(posedge clk);
      #1;
      reset_n = 0;
      @(posedge clk);
      #1;
      reset_n = 1;
      mem_q.delete();
      rf_q.delete();
      ld_ack_q.delete();
      @(negedge clk);
      check_reset_outputs();
      repeat (6) @(negedge clk);
      chk("no_wb_after_reset", 32'(busy), 0);
      run(16'h0A0A, 32'h0000_0900, 0, 0, 1, 1, 4'd4, 0, 1, 0);
      for (int t = 0; t < 40; t++) begin
         logic [15:0] l;
         int d;
         l = $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom);
         d = $urandom_range(0, 3);
         run(l, $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), d, d == 0, d != 0 && l != 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
